// File: rtl/axi4_lite_cfg_master.sv
// AXI4-Lite initiator for the camera configuration register port.
// One outstanding command; a per-state watchdog converts a hung slave into an error response.
module axi4_lite_cfg_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

    state_t          state;
    logic            aw_done, w_done;
    logic [WD_W-1:0] wdog;
    logic            aw_hs, w_hs, aw_fin, w_fin;
    logic            progress, waiting, wd_expired, abort;

    assign AWPROT = 3'b000;
    assign ARPROT = 3'b000;

    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    // progress = the handshake that leaves the current wait state happens this edge
    always_comb begin
        progress = 1'b0;
        waiting  = 1'b1;
        case (state)
            WR:      progress = aw_fin && w_fin;
            WR_RESP: progress = BVALID && BREADY;
            RD_ADDR: progress = ARVALID && ARREADY;
            RD_DATA: progress = RVALID && RREADY;
            default: waiting  = 1'b0;
        endcase
    end

    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wdog == WD_LAST);
    assign abort      = waiting && !progress && wd_expired;

    always_ff @(posedge ACLK) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            AWADDR      <= '0;
            AWVALID     <= 1'b0;
            WDATA       <= '0;
            WSTRB       <= '0;
            WVALID      <= 1'b0;
            BREADY      <= 1'b0;
            ARADDR      <= '0;
            ARVALID     <= 1'b0;
            RREADY      <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            wdog        <= '0;
        end else if (abort) begin
            // Deliberately drops VALID mid-handshake; only reached with a hung slave.
            AWVALID     <= 1'b0;
            WVALID      <= 1'b0;
            BREADY      <= 1'b0;
            ARVALID     <= 1'b0;
            RREADY      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_resp    <= 2'b10;
            rsp_rdata   <= '0;
            state       <= RSP;
        end else begin
            if (waiting)
                wdog <= progress ? '0 : wdog + 1'b1;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        wdog      <= '0;
                        if (cmd_write) begin
                            AWADDR  <= cmd_addr;
                            WDATA   <= cmd_wdata;
                            WSTRB   <= cmd_wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WR;
                        end else begin
                            ARADDR  <= cmd_addr;
                            ARVALID <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (progress) begin
                        BREADY <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: if (progress) begin
                    BREADY      <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_resp    <= BRESP;
                    rsp_rdata   <= '0;
                    rsp_timeout <= 1'b0;
                    state       <= RSP;
                end
                RD_ADDR: if (progress) begin
                    ARVALID <= 1'b0;
                    RREADY  <= 1'b1;
                    state   <= RD_DATA;
                end
                RD_DATA: if (progress) begin
                    RREADY      <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= RDATA;
                    rsp_resp    <= RRESP;
                    rsp_timeout <= 1'b0;
                    state       <= RSP;
                end
                RSP: if (rsp_ready) begin
                    // cmd_ready rises here so the next command can land one edge later
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_cfg_master.sv
// Directed bench for axi4_lite_cfg_master: configurable AXI slave, expected-response queue and
// an independent monitor that checks every rsp handshake against it.
module tb_axi4_lite_cfg_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } rsp_t;

    logic        ACLK = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    rsp_t        exp_q[$];
    string       name_q[$];

    int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    axi4_lite_cfg_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    // ---------------- slave model ----------------
    int unsigned aw_wait = 0, w_wait = 0, ar_wait = 0, b_cnt = 0, r_cnt = 0;
    logic        aw_seen = 1'b0, w_seen = 1'b0, ar_seen = 1'b0;
    logic        aw_now, w_now, ar_now;

    assign AWREADY = AWVALID && (aw_wait >= aw_delay);
    assign WREADY  = WVALID && (w_wait >= w_delay);
    assign ARREADY = ARVALID && (ar_wait >= ar_delay);
    assign aw_now  = aw_seen | (AWVALID & AWREADY);
    assign w_now   = w_seen | (WVALID & WREADY);
    assign ar_now  = ar_seen | (ARVALID & ARREADY);
    assign BRESP   = bresp_cfg;
    assign RRESP   = rresp_cfg;
    assign RDATA   = rdata_cfg;

    always @(posedge ACLK) begin
        if (reset) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
            BVALID <= 1'b0; RVALID <= 1'b0;
        end else begin
            aw_wait <= (!AWVALID || AWREADY) ? 0 : aw_wait + 1;
            w_wait  <= (!WVALID || WREADY) ? 0 : w_wait + 1;
            ar_wait <= (!ARVALID || ARREADY) ? 0 : ar_wait + 1;
            if (BVALID && BREADY) begin
                BVALID <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; b_cnt <= 0;
            end else begin
                aw_seen <= aw_now; w_seen <= w_now;
                if (aw_now && w_now && !BVALID) begin
                    if (b_cnt >= b_delay) BVALID <= 1'b1;
                    else b_cnt <= b_cnt + 1;
                end
            end
            if (RVALID && RREADY) begin
                RVALID <= 1'b0; ar_seen <= 1'b0; r_cnt <= 0;
            end else begin
                ar_seen <= ar_now;
                if (ar_now && !RVALID) begin
                    if (r_cnt >= r_delay) RVALID <= 1'b1;
                    else r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge ACLK) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=rsp_valid=1 required=no response pending");
            end else begin
                rsp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
                check({n, "_resp"}, 64'(rsp_resp), 64'(e.resp));
                check({n, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic push, input rsp_t e,
                         input string tag, output int unsigned acc);
        int unsigned n = 0;
        acc = 0;
        if (push) begin
            exp_q.push_back(e);
            name_q.push_back(tag);
        end
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
        while (!cmd_ready && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept actual=cmd_ready stuck low required=accepted within 200 cycles", tag);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge ACLK);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({cmd_ready, rsp_valid, rsp_timeout, rsp_resp, AWVALID, WVALID,
                                  BREADY, ARVALID, RREADY, AWPROT, ARPROT}), 64'(0));
        check({tag, "_addr"}, 64'({AWADDR, ARADDR, WSTRB}), 64'(0));
        check({tag, "_data"}, 64'({WDATA, rsp_rdata}), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=simulation still running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int unsigned a1, a2, a3, a4, rel;
        int unsigned aw_hi, w_hi, ar_hi, bad;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        @(negedge ACLK);
        check("ready_after_reset", 64'(cmd_ready), 64'(1));

        // zero-wait write: handshake timing and 4-cycle spacing
        issue(1'b1, 8'h10, 32'hA5A5_0001, 4'hF, 1'b1, rsp_t'{32'h0, 2'b00, 1'b0}, "wr10", a1);
        @(negedge ACLK);
        check("wr10_n1_valids", 64'({AWVALID, WVALID, BREADY, rsp_valid}), 64'(4'b1100));
        check("wr10_n1_payload", 64'({AWADDR, WSTRB, WDATA}), 64'({8'h10, 4'hF, 32'hA5A5_0001}));
        @(negedge ACLK);
        check("wr10_n2_bready", 64'({AWVALID, WVALID, BREADY, rsp_valid}), 64'(4'b0010));
        @(negedge ACLK);
        check("wr10_n3_rsp", 64'({BREADY, rsp_valid}), 64'(2'b01));
        issue(1'b1, 8'h14, 32'h0000_0002, 4'hF, 1'b1, rsp_t'{32'h0, 2'b00, 1'b0}, "wr14", a2);
        check("wr_spacing", 64'(a2 - a1), 64'(4));
        rdata_cfg = 32'h1111_2222;
        issue(1'b0, 8'h10, 32'h0, 4'h0, 1'b1, rsp_t'{32'h1111_2222, 2'b00, 1'b0}, "rd10", a3);
        check("wr_rd_spacing", 64'(a3 - a2), 64'(4));
        issue(1'b0, 8'h14, 32'h0, 4'h0, 1'b1, rsp_t'{32'h1111_2222, 2'b00, 1'b0}, "rd14", a4);
        check("rd_spacing", 64'(a4 - a3), 64'(4));
        wait_idle("t1");

        // AWREADY late by 3 cycles, WREADY immediate
        aw_delay = 3;
        issue(1'b1, 8'h18, 32'h0000_00C3, 4'h3, 1'b1, rsp_t'{32'h0, 2'b00, 1'b0}, "wr18", a1);
        aw_hi = 0; w_hi = 0; bad = 0;
        repeat (10) begin
            @(negedge ACLK);
            if (AWVALID) begin
                aw_hi++;
                if (AWADDR !== 8'h18) bad++;
            end
            if (WVALID) w_hi++;
        end
        check("wr18_awvalid_cycles", 64'(aw_hi), 64'(4));
        check("wr18_wvalid_cycles", 64'(w_hi), 64'(1));
        check("wr18_awaddr_stable", 64'(bad), 64'(0));
        wait_idle("t2");
        aw_delay = 0;

        // read with RVALID delayed 2 cycles, then DECERR pass-through
        r_delay = 2; rdata_cfg = 32'hDEAD_BEEF;
        issue(1'b0, 8'h24, 32'h0, 4'h0, 1'b1, rsp_t'{32'hDEAD_BEEF, 2'b00, 1'b0}, "rd24", a1);
        ar_hi = 0; bad = 0;
        repeat (8) begin
            @(negedge ACLK);
            if (ARVALID) begin
                ar_hi++;
                if (ARADDR !== 8'h24) bad++;
            end
        end
        check("rd24_arvalid_cycles", 64'(ar_hi), 64'(1));
        check("rd24_araddr", 64'(bad), 64'(0));
        wait_idle("t3");
        r_delay = 0; rresp_cfg = 2'b11; rdata_cfg = 32'h0BAD_F00D;
        issue(1'b0, 8'h28, 32'h0, 4'h0, 1'b1, rsp_t'{32'h0BAD_F00D, 2'b11, 1'b0}, "rd28", a1);
        wait_idle("t3b");
        rresp_cfg = 2'b00;

        // SLVERR write under 5 cycles of response backpressure
        bresp_cfg = 2'b10; rsp_ready = 1'b0;
        issue(1'b1, 8'h30, 32'h0000_0055, 4'h1, 1'b1, rsp_t'{32'h0, 2'b10, 1'b0}, "wr30", a1);
        bad = 0;
        while (!rsp_valid && bad < 50) begin
            @(negedge ACLK);
            bad++;
        end
        for (int i = 0; i < 5; i++) begin
            check("wr30_held", 64'({rsp_valid, rsp_resp, rsp_timeout, cmd_ready}), 64'(5'b1_10_0_0));
            @(negedge ACLK);
        end
        rsp_ready = 1'b1;
        rel = cyc;
        bresp_cfg = 2'b00;
        rdata_cfg = 32'h0000_3434;
        issue(1'b0, 8'h34, 32'h0, 4'h0, 1'b1, rsp_t'{32'h0000_3434, 2'b00, 1'b0}, "rd34", a2);
        check("rd34_accept_after_release", 64'(a2 - rel), 64'(2));
        wait_idle("t4");

        // ARREADY never comes: watchdog abort after 16 cycles
        ar_delay = 1000; rdata_cfg = 32'hFFFF_FFFF;
        issue(1'b0, 8'h40, 32'h0, 4'h0, 1'b1, rsp_t'{32'h0, 2'b10, 1'b1}, "rd40_to", a1);
        ar_hi = 0;
        repeat (30) begin
            @(negedge ACLK);
            if (ARVALID) ar_hi++;
        end
        check("rd40_arvalid_cycles", 64'(ar_hi), 64'(16));
        check("rd40_arvalid_low", 64'({ARVALID, RREADY}), 64'(0));
        wait_idle("t5");
        ar_delay = 0;

        // reset while waiting in WR_RESP, then a clean read
        b_delay = 5;
        issue(1'b1, 8'h50, 32'h1234_5678, 4'hF, 1'b0, rsp_t'{32'h0, 2'b00, 1'b0}, "wr50", a1);
        @(negedge ACLK);
        @(negedge ACLK);
        check("wr50_in_wr_resp", 64'({AWVALID, WVALID, BREADY}), 64'(3'b001));
        reset = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        b_delay = 0; rdata_cfg = 32'hCAFE_0123;
        issue(1'b0, 8'h5C, 32'h0, 4'h0, 1'b1, rsp_t'{32'hCAFE_0123, 2'b00, 1'b0}, "rd5c", a1);
        wait_idle("t6");

        repeat (3) @(negedge ACLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
